// File: rtl/dual_side_xbar_switch_if.sv
// Port bundle for the two-sided crossbar: NP source/destination ports on side X and side Y.
// The switch takes the slave modport; the endpoint groups take the master modport.
interface dual_side_xbar_switch_if #(
    parameter int DW = 4,
    parameter int NP = 4
);
    localparam int AW = $clog2(NP);

    logic [NP-1:0]    x_validtx_i;
    logic [NP*AW-1:0] x_adr_i;
    logic [NP*DW-1:0] x_dat_i;
    logic [NP-1:0]    x_acktx_o;
    logic [NP-1:0]    x_validrx_o;
    logic [NP*DW-1:0] x_dat_o;
    logic [NP-1:0]    x_ackrx_i;

    logic [NP-1:0]    y_validtx_i;
    logic [NP*AW-1:0] y_adr_i;
    logic [NP*DW-1:0] y_dat_i;
    logic [NP-1:0]    y_acktx_o;
    logic [NP-1:0]    y_validrx_o;
    logic [NP*DW-1:0] y_dat_o;
    logic [NP-1:0]    y_ackrx_i;

    modport slave (
        input  x_validtx_i, x_adr_i, x_dat_i, x_ackrx_i,
        input  y_validtx_i, y_adr_i, y_dat_i, y_ackrx_i,
        output x_acktx_o, x_validrx_o, x_dat_o,
        output y_acktx_o, y_validrx_o, y_dat_o
    );

    modport master (
        output x_validtx_i, x_adr_i, x_dat_i, x_ackrx_i,
        output y_validtx_i, y_adr_i, y_dat_i, y_ackrx_i,
        input  x_acktx_o, x_validrx_o, x_dat_o,
        input  y_acktx_o, y_validrx_o, y_dat_o
    );
endinterface

// File: rtl/dual_side_xbar_switch.sv
// Parametrised two-sided crossbar: per-destination round-robin arbiter feeding a DEPTH-entry FIFO.
// Optional feature macro SWITCH_STATS_EN adds saturating 16-bit accepted-word counters per side.

// One direction of the switch: NP sources fanning into NP destination FIFOs.
module dual_side_xbar_dir #(
    parameter int DW    = 4,
    parameter int NP    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NP-1:0]            validtx,
    input  logic [NP*$clog2(NP)-1:0] adr,
    input  logic [NP*DW-1:0]         dat,
    output logic [NP-1:0]            acktx,
    output logic [NP-1:0]            validrx,
    output logic [NP*DW-1:0]         dout,
    input  logic [NP-1:0]            ackrx
);
    localparam int AW = $clog2(NP);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [NP-1:0][AW-1:0]             src_adr;
    logic [NP-1:0][DW-1:0]             src_dat;
    logic [NP-1:0][NP-1:0]             req;
    logic [NP-1:0][AW-1:0]             rr;
    logic [NP-1:0][AW-1:0]             gnt_idx;
    logic [NP-1:0]                     gnt_any;
    logic [NP-1:0]                     push;
    logic [NP-1:0]                     pop;
    logic [NP-1:0][DEPTH-1:0][DW-1:0]  mem;
    logic [NP-1:0][PW-1:0]             wr_ptr;
    logic [NP-1:0][PW-1:0]             rd_ptr;
    logic [NP-1:0][PW:0]               count;

    assign src_adr = adr;
    assign src_dat = dat;

    // req[d][s]: source s currently addresses destination d
    always_comb begin
        req = '0;
        for (int d = 0; d < NP; d++) begin
            for (int s = 0; s < NP; s++) begin
                req[d][s] = validtx[s] && (src_adr[s] == AW'(d));
            end
        end
    end

    // Scan from rr downwards so the lowest offset from rr is the last (winning) assignment.
    always_comb begin : arbitration
        logic [AW-1:0] idx;
        idx     = '0;
        gnt_idx = '0;
        gnt_any = '0;
        for (int d = 0; d < NP; d++) begin
            for (int k = NP - 1; k >= 0; k--) begin
                idx = rr[d] + AW'(k);
                if (req[d][idx]) begin
                    gnt_any[d] = 1'b1;
                    gnt_idx[d] = idx;
                end
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        push  = '0;
        pop   = '0;
        acktx = '0;
        for (int d = 0; d < NP; d++) begin
            push[d] = gnt_any[d] && (count[d] != FULL) && !rst;
            pop[d]  = ackrx[d] && (count[d] != '0);
        end
        for (int d = 0; d < NP; d++) begin
            for (int s = 0; s < NP; s++) begin
                if (push[d] && (gnt_idx[d] == AW'(s))) acktx[s] = 1'b1;
            end
        end
    end

    for (genvar d = 0; d < NP; d++) begin : g_out
        assign validrx[d]         = (count[d] != '0);
        assign dout[d*DW +: DW]   = mem[d][rd_ptr[d]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= '0;
        end else begin
            for (int d = 0; d < NP; d++) begin
                if (push[d]) begin
                    mem[d][wr_ptr[d]] <= src_dat[gnt_idx[d]];
                    wr_ptr[d]         <= wr_ptr[d] + 1'b1;
                    rr[d]             <= gnt_idx[d] + 1'b1;
                end
                if (pop[d]) rd_ptr[d] <= rd_ptr[d] + 1'b1;
                case ({push[d], pop[d]})
                    2'b10:   count[d] <= count[d] + 1'b1;
                    2'b01:   count[d] <= count[d] - 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

module dual_side_xbar_switch #(
    parameter int DW    = 4,
    parameter int NP    = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    dual_side_xbar_switch_if.slave bus
`ifdef SWITCH_STATS_EN
    ,
    output logic [15:0]            x_txcnt_o,
    output logic [15:0]            y_txcnt_o
`endif
);
    dual_side_xbar_dir #(.DW(DW), .NP(NP), .DEPTH(DEPTH)) u_x_to_y (
        .clk     (clk_i),
        .rst     (rst_i),
        .validtx (bus.x_validtx_i),
        .adr     (bus.x_adr_i),
        .dat     (bus.x_dat_i),
        .acktx   (bus.x_acktx_o),
        .validrx (bus.y_validrx_o),
        .dout    (bus.y_dat_o),
        .ackrx   (bus.y_ackrx_i)
    );

    dual_side_xbar_dir #(.DW(DW), .NP(NP), .DEPTH(DEPTH)) u_y_to_x (
        .clk     (clk_i),
        .rst     (rst_i),
        .validtx (bus.y_validtx_i),
        .adr     (bus.y_adr_i),
        .dat     (bus.y_dat_i),
        .acktx   (bus.y_acktx_o),
        .validrx (bus.x_validrx_o),
        .dout    (bus.x_dat_o),
        .ackrx   (bus.x_ackrx_i)
    );

`ifdef SWITCH_STATS_EN
    // A 17-bit sum catches the carry out of 16 bits, which is where the counter pins at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [NP-1:0] acks);
        logic [16:0] sum;
        sum = {1'b0, cnt};
        for (int s = 0; s < NP; s++) sum = sum + 17'(acks[s]);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_txcnt_o <= '0;
            y_txcnt_o <= '0;
        end else begin
            x_txcnt_o <= sat_add(x_txcnt_o, bus.x_acktx_o);
            y_txcnt_o <= sat_add(y_txcnt_o, bus.y_acktx_o);
        end
    end
`endif
endmodule

// File: tb/tb_dual_side_xbar_switch.sv
// Randomised + directed bench for dual_side_xbar_switch against a queue-based reference model.
// Define SWITCH_STATS_EN to also cover the accepted-word counters.
module tb_dual_side_xbar_switch;
    localparam int DW    = 4;
    localparam int NP    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_side_xbar_switch_if #(.DW(DW), .NP(NP)) bus ();
`ifdef SWITCH_STATS_EN
    logic [15:0] x_txcnt, y_txcnt;
`endif

    dual_side_xbar_switch #(.DW(DW), .NP(NP), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef SWITCH_STATS_EN
        ,
        .x_txcnt_o (x_txcnt),
        .y_txcnt_o (y_txcnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: q[dir*NP+d] holds the words queued for destination d of direction dir
    // (dir 0 = X sources into Y FIFOs, dir 1 = Y sources into X FIFOs).
    logic [DW-1:0] q [2*NP][$];
    int            rr [2*NP];
    logic [NP-1:0] exp_ack [2];
    int            exp_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2*NP; i++) begin
            q[i].delete();
            rr[i] = 0;
        end
        exp_ack[0] = '0;
        exp_ack[1] = '0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model
    // to what the coming rising edge must produce.
    task automatic eval();
        if (rst) begin
            model_reset();
            chk("rst_xack", 32'(bus.x_acktx_o), 32'h0);
            chk("rst_yack", 32'(bus.y_acktx_o), 32'h0);
            chk("rst_xvld", 32'(bus.x_validrx_o), 32'h0);
            chk("rst_yvld", 32'(bus.y_validrx_o), 32'h0);
            chk("rst_xdat", 32'(bus.x_dat_o), 32'h0);
            chk("rst_ydat", 32'(bus.y_dat_o), 32'h0);
`ifdef SWITCH_STATS_EN
            chk("rst_xcnt", 32'(x_txcnt), 32'h0);
            chk("rst_ycnt", 32'(y_txcnt), 32'h0);
`endif
            return;
        end
`ifdef SWITCH_STATS_EN
        chk("xcnt", 32'(x_txcnt), 32'(exp_cnt[0]));
        chk("ycnt", 32'(y_txcnt), 32'(exp_cnt[1]));
`endif
        for (int dir = 0; dir < 2; dir++) begin
            logic [NP-1:0]    v, ackrx, d_ack, d_vrx, e_ack, e_vrx;
            logic [NP*AW-1:0] a;
            logic [NP*DW-1:0] dt, d_dat;
            int               g [NP];
            string            sn;
            sn    = (dir == 0) ? "x>y" : "y>x";
            v     = (dir == 0) ? bus.x_validtx_i : bus.y_validtx_i;
            a     = (dir == 0) ? bus.x_adr_i     : bus.y_adr_i;
            dt    = (dir == 0) ? bus.x_dat_i     : bus.y_dat_i;
            ackrx = (dir == 0) ? bus.y_ackrx_i   : bus.x_ackrx_i;
            d_ack = (dir == 0) ? bus.x_acktx_o   : bus.y_acktx_o;
            d_vrx = (dir == 0) ? bus.y_validrx_o : bus.x_validrx_o;
            d_dat = (dir == 0) ? bus.y_dat_o     : bus.x_dat_o;
            e_ack = '0;
            e_vrx = '0;
            for (int d = 0; d < NP; d++) begin
                int qi;
                qi   = dir*NP + d;
                g[d] = -1;
                for (int k = 0; k < NP; k++) begin
                    int s;
                    s = (rr[qi] + k) % NP;
                    if (g[d] < 0 && v[s] && int'(a[s*AW +: AW]) == d) g[d] = s;
                end
                if (q[qi].size() >= DEPTH) g[d] = -1;
                if (g[d] >= 0) e_ack[g[d]] = 1'b1;
                e_vrx[d] = (q[qi].size() != 0);
            end
            chk({sn, "_ack"}, 32'(d_ack), 32'(e_ack));
            chk({sn, "_vld"}, 32'(d_vrx), 32'(e_vrx));
            for (int d = 0; d < NP; d++) begin
                int qi;
                qi = dir*NP + d;
                if (q[qi].size() != 0) chk({sn, "_dat"}, 32'(d_dat[d*DW +: DW]), 32'(q[qi][0]));
                if (ackrx[d] && q[qi].size() != 0) void'(q[qi].pop_front());
                if (g[d] >= 0) begin
                    q[qi].push_back(dt[g[d]*DW +: DW]);
                    rr[qi] = (g[d] + 1) % NP;
                end
            end
            exp_ack[dir] = e_ack;
            exp_cnt[dir] = exp_cnt[dir] + $countones(e_ack);
            if (exp_cnt[dir] > 65535) exp_cnt[dir] = 65535;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.x_validtx_i = '0; bus.x_adr_i = '0; bus.x_dat_i = '0; bus.x_ackrx_i = '0;
        bus.y_validtx_i = '0; bus.y_adr_i = '0; bus.y_dat_i = '0; bus.y_ackrx_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        eval();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sources that were accepted (or idle) pick a fresh request; unaccepted ones hold their word.
    task automatic rand_drive();
        for (int dir = 0; dir < 2; dir++) begin
            logic [NP-1:0]    v;
            logic [NP*AW-1:0] a;
            logic [NP*DW-1:0] dt;
            v  = (dir == 0) ? bus.x_validtx_i : bus.y_validtx_i;
            a  = (dir == 0) ? bus.x_adr_i     : bus.y_adr_i;
            dt = (dir == 0) ? bus.x_dat_i     : bus.y_dat_i;
            for (int s = 0; s < NP; s++) begin
                if (!v[s] || exp_ack[dir][s]) begin
                    v[s]            = ($urandom % 4) != 0;
                    a[s*AW +: AW]   = AW'($urandom);
                    dt[s*DW +: DW]  = DW'($urandom);
                end
            end
            if (dir == 0) begin
                bus.x_validtx_i = v; bus.x_adr_i = a; bus.x_dat_i = dt;
            end else begin
                bus.y_validtx_i = v; bus.y_adr_i = a; bus.y_dat_i = dt;
            end
        end
        bus.x_ackrx_i = NP'($urandom);
        bus.y_ackrx_i = NP'($urandom);
    endtask

    initial begin
        int w;
        logic e;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Requests held during reset get no ack; on release each distinct destination acks at once.
        bus.x_validtx_i = 4'hF;
        bus.x_adr_i     = 8'hE4;
        bus.x_dat_i     = 16'h4321;
        @(negedge clk);
        eval();
        rst = 1'b0;
        #1;
        eval();
        chk("rst_release_ack", 32'(bus.x_acktx_o), 32'hF);
        @(posedge clk);
        #1;

        // Single transfer X1 -> Y2
        do_reset();
        bus.x_validtx_i = 4'b0010;
        bus.x_adr_i     = 8'b00_00_10_00;
        bus.x_dat_i     = 16'h00A0;
        @(negedge clk);
        eval();
        chk("single_ack", 32'(bus.x_acktx_o), 32'h2);
        @(posedge clk);
        #1;
        bus.x_validtx_i = '0;
        @(negedge clk);
        eval();
        chk("single_vld", 32'(bus.y_validrx_o[2]), 32'h1);
        chk("single_dat", 32'(bus.y_dat_o[11:8]), 32'hA);
        @(posedge clk);
        #1;
        bus.y_ackrx_i = 4'b0100;
        tick();
        bus.y_ackrx_i = '0;
        @(negedge clk);
        eval();
        chk("single_drop", 32'(bus.y_validrx_o[2]), 32'h0);
        @(posedge clk);
        #1;

        // Round-robin: all X sources on Y0, Y0 drained every cycle
        do_reset();
        bus.x_validtx_i = 4'hF;
        bus.x_adr_i     = '0;
        bus.x_dat_i     = 16'h3210;
        bus.y_ackrx_i   = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            eval();
            chk("rr_ack", 32'(bus.x_acktx_o), 32'(1 << (i % 4)));
            @(posedge clk);
            #1;
        end

        // Full FIFO backpressure on Y3 with ordered data 1..5
        do_reset();
        w = 1;
        bus.x_validtx_i = 4'b0001;
        bus.x_adr_i     = 8'h03;
        bus.x_dat_i     = 16'(w);
        for (int i = 0; i < 8; i++) begin
            bus.y_ackrx_i = (i == 6) ? 4'b1000 : 4'b0000;
            e = (i < 4) || (i == 7);
            @(negedge clk);
            eval();
            chk("full_ack", 32'(bus.x_acktx_o[0]), 32'(e));
            @(posedge clk);
            #1;
            if (e) w++;
            bus.x_dat_i = 16'(w);
        end
        bus.x_validtx_i = '0;
        bus.y_ackrx_i   = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            eval();
            chk("full_order", 32'(bus.y_dat_o[15:12]), 32'(k + 2));
            @(posedge clk);
            #1;
        end
        bus.y_ackrx_i = '0;

        // Parallel, both directions in one cycle
        do_reset();
        bus.x_validtx_i = 4'b0011;
        bus.x_adr_i     = 8'h04;
        bus.x_dat_i     = 16'h00C5;
        bus.y_validtx_i = 4'b1100;
        bus.y_adr_i     = 8'hB0;
        bus.y_dat_i     = 16'h9E00;
        @(negedge clk);
        eval();
        chk("par_xack", 32'(bus.x_acktx_o), 32'h3);
        chk("par_yack", 32'(bus.y_acktx_o), 32'hC);
        @(posedge clk);
        #1;
        bus.x_validtx_i = '0;
        bus.y_validtx_i = '0;
        @(negedge clk);
        eval();
        chk("par_yvld", 32'(bus.y_validrx_o), 32'h3);
        chk("par_xvld", 32'(bus.x_validrx_o), 32'hC);
        @(posedge clk);
        #1;

        // Random traffic with a mid-run asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            if (i == 1500) rst = 1'b1;
            if (i == 1503) rst = 1'b0;
            tick();
        end

`ifdef SWITCH_STATS_EN
        // Four X words per cycle into always-drained Y FIFOs: saturates x counter, y stays 0
        do_reset();
        bus.x_validtx_i = 4'hF;
        bus.x_adr_i     = 8'hE4;
        bus.x_dat_i     = 16'h5A5A;
        bus.y_ackrx_i   = 4'hF;
        for (int i = 0; i < 17600; i++) tick();
        @(negedge clk);
        chk("stat_xsat", 32'(x_txcnt), 32'hFFFF);
        chk("stat_y", 32'(y_txcnt), 32'h0);
        @(posedge clk);
        #1;
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
